// File: rtl/cram_pkg.sv
// Shared types and default sizes for the CRAM loader and fabric-level benches.
package cram_pkg;

  localparam int CRAM_WORD_W    = 32;
  localparam int CRAM_CHAIN_LEN = 4096;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    SHIFT,
    DONE
  } cram_ld_state_t;

endpackage

// File: rtl/cram_rb_deser.sv
// Readback deserializer: collects the bits returned by the CRAM chain
// into words, LSB first, with a partial final word zero-padded.
module cram_rb_deser #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              last,
  input  logic              clr,
  input  logic              bit_in,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid
);

  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [BW-1:0]     bcnt;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] acc_n;
  logic              full;

  always_comb begin
    acc_n       = acc;
    acc_n[bcnt] = bit_in;
  end

  assign full = (bcnt == BW'(WORD_W - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bcnt     <= '0;
      acc      <= '0;
      rb_word  <= '0;
      rb_valid <= 1'b0;
    end else if (clr) begin
      bcnt     <= '0;
      acc      <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (en) begin
        if (full || last) begin
          rb_word  <= acc_n;
          rb_valid <= 1'b1;
          acc      <= '0;
          bcnt     <= '0;
        end else begin
          acc  <= acc_n;
          bcnt <= bcnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cram_loader.sv
// Serial CRAM chain loader: streams host words LSB-first into the fabric
// and returns the displaced chain contents as readback words.
module cram_loader
  import cram_pkg::*;
#(
  parameter int WORD_W    = CRAM_WORD_W,
  parameter int CHAIN_LEN = CRAM_CHAIN_LEN
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cram_data,
  output logic              cram_en,
  input  logic              cram_return,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int LW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN);

  cram_ld_state_t state;

  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic [CW-1:0]     base;
  logic [CW-1:0]     rem;
  logic [LW-1:0]     wleft;
  logic [LW-1:0]     load_len;
  logic [WORD_W-1:0] sreg;
  logic              hs;
  logic              word_end;
  logic              last_bit;
  logic              take;
  logic              idle_like;
  logic              rb_clr;

  assign hs        = word_valid & word_ready;
  assign cnt_n     = cnt + CW'(1);
  assign word_end  = (state == SHIFT) && (wleft == LW'(1));
  assign last_bit  = word_end && (cnt_n == LAST);
  assign idle_like = (state == IDLE) || (state == DONE);

  // Bits already in the chain when the next word starts shifting.
  assign base = (state == SHIFT) ? cnt_n : cnt;
  assign rem  = LAST - base;

  assign load_len = (int'(rem) < WORD_W) ? LW'(rem) : LW'(WORD_W);

  assign take = hs && ((state == LOAD_WAIT) || (word_end && !last_bit));

  assign rb_clr = abort || (start && idle_like);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      cnt        <= '0;
      wleft      <= '0;
      sreg       <= '0;
      cram_data  <= 1'b0;
      cram_en    <= 1'b0;
      word_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      cram_en    <= 1'b0;
      word_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD_WAIT;
            cnt        <= '0;
            word_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        LOAD_WAIT: ;
        SHIFT: begin
          cnt <= cnt_n;
          if (word_end) begin
            if (last_bit) begin
              state      <= DONE;
              cram_en    <= 1'b0;
              word_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else if (!hs) begin
              state      <= LOAD_WAIT;
              cram_en    <= 1'b0;
              word_ready <= 1'b1;
            end
          end else begin
            wleft      <= wleft - LW'(1);
            cram_data  <= sreg[0];
            sreg       <= sreg >> 1;
            // Open the handshake one cycle early so the next word
            // follows with no bubble.
            word_ready <= (wleft == LW'(2)) &&
                          (int'(cnt_n) + 1 < CHAIN_LEN);
          end
        end
        default: state <= IDLE;
      endcase

      if (take) begin
        state      <= SHIFT;
        cram_en    <= 1'b1;
        cram_data  <= word_in[0];
        sreg       <= word_in >> 1;
        wleft      <= load_len;
        word_ready <= (load_len == LW'(1)) &&
                      (int'(base) + 1 < CHAIN_LEN);
      end
    end
  end

  cram_rb_deser #(
    .WORD_W(WORD_W)
  ) u_rb_deser (
    .clk     (clk),
    .nrst    (nrst),
    .en      (cram_en),
    .last    (last_bit),
    .clr     (rb_clr),
    .bit_in  (cram_return),
    .rb_word (rb_word),
    .rb_valid(rb_valid)
  );

endmodule

// File: tb/tb_cram_loader.sv
// Scoreboard bench for cram_loader against a 40-bit chain model.
module tb_cram_loader;

  localparam int W = 16;
  localparam int L = 40;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] word_in = '0;
  logic         word_valid = 1'b0;
  logic         word_ready;
  logic         cram_data;
  logic         cram_en;
  logic         cram_return;
  logic [W-1:0] rb_word;
  logic         rb_valid;
  logic         busy;
  logic         done;

  logic [L-1:0] chain = '0;
  logic [L-1:0] pl_val = '0;
  logic         pl = 1'b0;

  logic [W-1:0] q [$];
  int checks = 0;
  int failures = 0;

  cram_loader #(
    .WORD_W   (W),
    .CHAIN_LEN(L)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .abort      (abort),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .cram_data  (cram_data),
    .cram_en    (cram_en),
    .cram_return(cram_return),
    .rb_word    (rb_word),
    .rb_valid   (rb_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Fabric chain: first bit in ends up at chain[0].
  always @(posedge clk) begin
    if (pl) chain <= pl_val;
    else if (cram_en) chain <= {cram_data, chain[L-1:1]};
  end

  assign cram_return = chain[0];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rb_valid) begin
      if (q.size() == 0) chk("rb_extra", rb_valid, 0);
      else chk("rb_word", rb_word, q.pop_front());
    end
  end

  task automatic preload(input logic [L-1:0] v);
    pl_val = v;
    pl = 1'b1;
    @(posedge clk);
    #1 pl = 1'b0;
  endtask

  task automatic run_load(input logic [W-1:0] w0,
                          input logic [W-1:0] w1,
                          input logic [W-1:0] w2,
                          input int stall,
                          input int abort_at,
                          input int restart_at);
    logic [W-1:0] w [3];
    logic [L-1:0] exp_chain;
    int idx, en_cnt, first_en, gap, done_at, stall_left, nw;
    bit hs, pend, aborted;
    w[0] = w0;
    w[1] = w1;
    w[2] = w2;
    idx = 0; en_cnt = 0; first_en = 0; gap = 0;
    done_at = 0; stall_left = 0; pend = 0; aborted = 0;
    exp_chain = {w2[7:0], w1, w0};
    nw = (abort_at == 0) ? 3 : abort_at / W;
    if (nw > 0) q.push_back(chain[15:0]);
    if (nw > 1) q.push_back(chain[31:16]);
    if (nw > 2) q.push_back({8'h00, chain[39:32]});
    abort = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    word_valid = 1'b1;
    word_in = w[0];
    for (int c = 1; c < 300; c++) begin
      @(negedge clk);
      if (done) begin
        done_at = c;
        break;
      end
      if (cram_en) begin
        en_cnt++;
        if (first_en == 0) first_en = c;
      end else if (first_en != 0) begin
        gap++;
      end
      if (pend && !word_valid && word_ready) stall_left--;
      hs = word_valid && word_ready;
      @(posedge clk);
      #1;
      if (start) start = 1'b0;
      if (restart_at != 0 && en_cnt == restart_at) start = 1'b1;
      if (abort_at != 0 && en_cnt == abort_at) begin
        abort = 1'b1;
        word_valid = 1'b0;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_en", cram_en, 0);
        chk("abort_rdy", word_ready, 0);
        chk("abort_done", done, 0);
        aborted = 1;
        break;
      end
      if (hs) begin
        idx++;
        if (idx < 3) begin
          if (idx == 1 && stall > 0) begin
            word_valid = 1'b0;
            pend = 1;
            stall_left = stall;
          end else begin
            word_in = w[idx];
          end
        end else begin
          word_valid = 1'b0;
        end
      end
      if (pend && stall_left == 0) begin
        pend = 0;
        word_valid = 1'b1;
        word_in = w[idx];
      end
    end
    word_valid = 1'b0;
    start = 1'b0;
    if (aborted) begin
      repeat (20) @(negedge clk);
      chk("abort_rb_left", q.size(), 0);
    end else begin
      chk("first_en", first_en, 2);
      chk("en_count", en_cnt, L);
      chk("en_gap", gap, stall);
      chk("done_cycle", done_at, 42 + stall);
      chk("chain", chain, exp_chain);
      @(posedge clk);
      #1;
      chk("rb_count", q.size(), 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", word_ready, 0);
    chk("rst_data", cram_data, 0);
    chk("rst_en", cram_en, 0);
    chk("rst_rbv", rb_valid, 0);
    chk("rst_rbw", rb_word, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    preload('0);
    run_load(16'hA5A5, 16'h0F0F, 16'h00FF, 0, 0, 0);
    chk("load1_chain", chain, 40'h0FF_0F0F_A5A5);

    @(negedge clk);
    chk("done_hold", done, 1);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("sa_done", done, 0);
    chk("sa_busy", busy, 0);
    chk("sa_rdy", word_ready, 0);

    preload(40'h12_3456_789A);
    run_load(16'h1111, 16'h2222, 16'hAB33, 0, 0, 0);

    preload('0);
    run_load(16'hA5A5, 16'h0F0F, 16'h00FF, 5, 0, 0);
    chk("stall_chain", chain, 40'h0FF_0F0F_A5A5);

    preload(40'h12_3456_789A);
    run_load(16'hDEAD, 16'hBEEF, 16'hC3C3, 0, 20, 0);
    preload(40'hAA_5555_CCCC);
    run_load(16'h1357, 16'h2468, 16'h9A9A, 0, 0, 0);

    @(posedge clk);
    #1 start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("sa_idle_busy", busy, 0);
    chk("sa_idle_rdy", word_ready, 0);
    chk("sa_idle_en", cram_en, 0);

    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    word_valid = 1'b1;
    word_in = 16'hFFFF;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_en", cram_en, 1);
    chk("pre_rst_busy", busy, 1);
    nrst = 1'b0;
    #1;
    chk("arst_en", cram_en, 0);
    chk("arst_data", cram_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rdy", word_ready, 0);
    chk("arst_done", done, 0);
    word_valid = 1'b0;
    @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk);
    #1;

    preload(40'h12_3456_789A);
    run_load(16'h0001, 16'h8000, 16'h7E7E, 0, 0, 5);

    repeat (5) @(posedge clk);
    #1;
    chk("final_q", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cram_loader.md
# cram_loader

Configuration bitstream loader and readback engine for the fabric's serial CRAM chain. Accepts configuration words from a host over a valid/ready handshake, serializes them LSB-first onto the fabric's `config_data_in` / `config_en` pins, and counts exactly `CHAIN_LEN` shifted bits. While shifting, it captures the previous chain contents emerging on `config_data_out` and returns them to the host as readback words. It sits between the host or bus interface and the top-level fabric.

## Interface
- `WORD_W`, 32, width of host load words and readback words.
- `CHAIN_LEN`, 4096, total CRAM bits in the fabric chain (≥1; need not be a multiple of `WORD_W`).
- `clk` input 1: single clock, shared with the fabric CRAM clock.
- `nrst` input 1: reset, asynchronous and active-low.
- `start` input 1: one-cycle pulse; begins a load. Ignored unless in IDLE or DONE.
- `abort` input 1: returns to IDLE immediately; has priority over every other input.
- `word_in` input `WORD_W`: load word; bit 0 is shifted first.
- `word_valid` input 1: `word_in` valid.
- `word_ready` output 1: loader accepts `word_in`.
- `cram_data` output 1: drives the fabric `config_data_in`.
- `cram_en` output 1: drives the fabric `config_en`; the fabric shifts one bit per cycle while it is high.
- `cram_return` input 1: from the fabric `config_data_out`.
- `rb_word` output `WORD_W`: readback word, LSB is the first bit returned.
- `rb_valid` output 1: one-cycle pulse, `rb_word` valid. No backpressure.
- `busy` output 1: high in LOAD_WAIT and SHIFT.
- `done` output 1: high in DONE.

## Operation
- States:
  - IDLE: `start` → LOAD_WAIT, and clears the bit counter.
  - LOAD_WAIT: `word_ready`=1. Handshake (`word_valid`&`word_ready`) → SHIFT, latching the word.
  - SHIFT: shifts one bit per cycle.
    - After `min(WORD_W, remaining)` bits, go to DONE if remaining==0.
    - Otherwise go to SHIFT if a new word was accepted in the last shift cycle, else LOAD_WAIT.
  - DONE: `start` → LOAD_WAIT, beginning a new load.
- Lookahead: `word_ready` is also high during the final shift cycle of a word when remaining after that cycle is >0. This gives gapless streaming.
- Bit counter: width `$clog2(CHAIN_LEN+1)`. It counts shifted bits and never exceeds `CHAIN_LEN`.
  - Final partial word: only its low `CHAIN_LEN mod WORD_W` bits are shifted; upper bits are discarded.
- Readback:
  - `cram_return` is sampled on every edge where `cram_en`=1, filling `rb_word` LSB-first.
  - `rb_valid` pulses the cycle after the `WORD_W`-th sample, or after the final sample of the load. A partial final readback word is zero-padded in its upper bits.
- `abort`: forces IDLE next cycle.
  - `cram_en`=0 and `word_ready`=0.
  - Pending readback is discarded and the partial chain is left as-is.
- Simultaneous `start`&`abort` → IDLE.
- `start` while busy is ignored.

## Timing
- Reset values: state IDLE; `word_ready`, `cram_data`, `cram_en`, `rb_valid`, `busy`, `done` = 0; `rb_word` = 0; counters = 0.
- `cram_data`/`cram_en` are registered. For a word accepted at edge t, bit 0 appears with `cram_en`=1 in cycle t+1, and bit k in cycle t+1+k.
- Full load with an always-valid host: `start` at edge 0; first `cram_en` at cycle 2; exactly `CHAIN_LEN` contiguous `cram_en` cycles; `done`=1 the cycle after the last shift.
- Host stall: `cram_en` drops to 0 and `cram_data` holds while in LOAD_WAIT. No bit is lost or duplicated.
- `rb_valid` latency is one cycle after the sampling edge of the word's last bit.
- An asynchronous `nrst` assertion mid-load clears all state immediately.

## Structure
- Package `cram_pkg`: state enum `cram_ld_state_t` (IDLE, LOAD_WAIT, SHIFT, DONE) and default `WORD_W`/`CHAIN_LEN` constants, shared with fabric-level benches.
- One natural sub-module, `cram_rb_deser`: the readback deserializer (bit counter, shift-in register, `rb_valid` pulse), enabled by `cram_en`.

## Test plan
Benches use `WORD_W`=16 and `CHAIN_LEN`=40 against a 40-bit shift-register model of the fabric chain.
- Preload the chain with zeros; stream 0xA5A5, 0x0F0F, 0x00FF with `word_valid` held high → 40 contiguous `cram_en` cycles, and the chain holds bits 0x0FF_0F0F_A5A5 (low 8 bits of word 3). `done`=1 at cycle 42.
- Chain preloaded with 0x12_3456_789A, then a second load → `rb_word` 0x789A, 0x3456, 0x0012 (zero-padded), with exactly 3 `rb_valid` pulses.
- Host drops `word_valid` for 5 cycles between words 1 and 2 → `cram_en` low for those cycles, and final chain contents are identical to the no-stall case.
- `abort` asserted after 20 shifted bits → next cycle IDLE, `cram_en`=0, `word_ready`=0, no further `rb_valid`; a subsequent `start` completes a full 40-bit load.
- `nrst` asserted mid-SHIFT → all outputs 0 asynchronously; `start` during busy and `start`&`abort` together → no state change beyond IDLE.
